// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encoding and the bit-counter width helper.
package serial_add_pkg;

   // Controller states. Encoding 2'b11 is unused and recovers to IDLE.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   // Supported operand widths.
   localparam int MIN_WIDTH = 2;
   localparam int MAX_WIDTH = 32;

   // Bit-counter width: ceil(log2(width)), never less than one bit.
   function automatic int cnt_width(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/fa_bit.sv
// One-bit full adder: the single arithmetic cell shared across all bit
// positions of the serial addition.
module fa_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ cin;
   assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial addition controller: captures two operands on Start, feeds
// them LSB-first through one shared full adder over WIDTH cycles, then
// registers Sum/Carry and pulses Done for one cycle.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Sum,
   output logic             Carry
);

   localparam int             CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic             load;      // accept operands this edge
   logic             last;      // final bit is processed this edge
   logic [WIDTH-1:0] ra;
   logic [WIDTH-1:0] rb;
   logic [WIDTH-1:0] ps;
   logic [WIDTH-1:0] ps_nxt;
   logic             c;
   logic [CNT_W-1:0] cnt;
   logic             fa_s;
   logic             fa_co;

   fa_bit u_fa (
      .a   (ra[0]),
      .b   (rb[0]),
      .cin (c),
      .s   (fa_s),
      .co  (fa_co)
   );

   // The new sum bit enters at the MSB so that after WIDTH shifts bit 0
   // lines up at ps[0].
   assign ps_nxt = {fa_s, ps[WIDTH-1:1]};

   // Status outputs decode directly from the state register.
   assign Busy = (state == RUN);
   assign Done = (state == DONE);

   // State register.
   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and control decode.
   // NOTE: every signal driven here gets a default first; a path that skips
   // an assignment would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            if (Start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (cnt == LAST_BIT) begin
               last      = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (Start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand shift registers, carry flop, counter and result registers.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         ra    <= '0;
         rb    <= '0;
         ps    <= '0;
         c     <= 1'b0;
         cnt   <= '0;
         Sum   <= '0;
         Carry <= 1'b0;
      end else if (load) begin
         ra  <= A;
         rb  <= B;
         ps  <= '0;
         c   <= 1'b0;
         cnt <= '0;
      end else if (state == RUN) begin
         ra  <= {1'b0, ra[WIDTH-1:1]};
         rb  <= {1'b0, rb[WIDTH-1:1]};
         ps  <= ps_nxt;
         c   <= fa_co;
         cnt <= cnt + 1'b1;
         // Result is published only on the completion edge; it holds the
         // previous value throughout a run.
         if (last) begin
            Sum   <= ps_nxt;
            Carry <= fa_co;
         end
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: the driver decides from a simple
// timing model whether each Start is accepted and queues the expected
// A+B result with its Done cycle; a monitor checks every cycle.
module tb_serial_add_ctrl;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] sum;
      logic         carry;
      int           done_edge;
   } exp_t;

   logic         Clk = 1'b0;
   logic         Rst = 1'b1;
   logic         Start = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         Busy;
   logic         Done;
   logic [W-1:0] Sum;
   logic         Carry;

   int           total = 0;
   int           bad = 0;
   int           edge_n = 0;
   int           free_edge = 0;
   bit           mon_en = 1'b0;
   exp_t         q[$];
   logic [W-1:0] last_sum = '0;
   logic         last_carry = 1'b0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .Clk   (Clk),
      .Rst   (Rst),
      .Start (Start),
      .A     (A),
      .B     (B),
      .Busy  (Busy),
      .Done  (Done),
      .Sum   (Sum),
      .Carry (Carry)
   );

   always #5 Clk = ~Clk;

   // Count rising edges so expectations can be stated in edge numbers.
   always @(posedge Clk) edge_n <= edge_n + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   // Drive one cycle of stimulus; Start is accepted at the next edge only if
   // the previous addition has reached its Done cycle.
   task automatic cyc(input logic st, input logic [W-1:0] a, input logic [W-1:0] b);
      int   e;
      exp_t x;
      logic [W:0] full;
      @(negedge Clk);
      Start = st;
      A     = a;
      B     = b;
      e     = edge_n + 1;
      if (st && e >= free_edge) begin
         full        = {1'b0, a} + {1'b0, b};
         x.sum       = full[W-1:0];
         x.carry     = full[W];
         x.done_edge = e + W;
         q.push_back(x);
         free_edge   = e + W + 1;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, $urandom, $urandom);
   endtask

   // Monitor: compare status and result every cycle against the queue.
   always @(negedge Clk) begin
      if (mon_en && !Rst) begin
         automatic bit exp_done = (q.size() > 0) && (q[0].done_edge == edge_n);
         automatic bit exp_busy = (q.size() > 0) && (edge_n >= q[0].done_edge - W)
                                  && (edge_n < q[0].done_edge);
         check("done", {31'b0, Done}, {31'b0, exp_done});
         check("busy", {31'b0, Busy}, {31'b0, exp_busy});
         check("busy_and_done", {31'b0, Busy & Done}, 32'd0);
         if (exp_done) begin
            last_sum   = q[0].sum;
            last_carry = q[0].carry;
            void'(q.pop_front());
         end
         check("sum", {24'b0, Sum}, {24'b0, last_sum});
         check("carry", {31'b0, Carry}, {31'b0, last_carry});
      end
   end

   task automatic release_reset();
      @(negedge Clk);
      Rst       = 1'b0;
      free_edge = edge_n + 1;
      @(posedge Clk);
      #1 mon_en = 1'b1;
   endtask

   initial begin
      // Power-on reset and reset-state checks.
      repeat (2) @(negedge Clk);
      check("rst_busy", {31'b0, Busy}, 32'd0);
      check("rst_done", {31'b0, Done}, 32'd0);
      check("rst_sum", {24'b0, Sum}, 32'd0);
      check("rst_carry", {31'b0, Carry}, 32'd0);
      release_reset();

      // Directed cases.
      cyc(1'b1, 8'h00, 8'h00); idle(10);
      cyc(1'b1, 8'h5A, 8'h3C); idle(10);
      cyc(1'b1, 8'hFF, 8'h01); idle(10);
      cyc(1'b1, 8'hFF, 8'hFF); idle(10);

      // Start re-pulsed during RUN and operands changed after acceptance.
      cyc(1'b1, 8'h12, 8'h34);
      cyc(1'b0, 8'h77, 8'h88);
      cyc(1'b1, 8'h77, 8'h88);
      cyc(1'b1, 8'hAA, 8'hBB);
      idle(8);

      // Start held high: second operands presented in the DONE cycle.
      cyc(1'b1, 8'h01, 8'h02);
      for (int i = 0; i < W; i++) cyc(1'b1, 8'h01, 8'h02);
      cyc(1'b1, 8'h10, 8'h20);
      idle(11);

      // Abort during RUN after a prior 0x96 result.
      cyc(1'b1, 8'h5A, 8'h3C); idle(10);
      cyc(1'b1, 8'h11, 8'h22);
      cyc(1'b0, 8'h00, 8'h00);
      cyc(1'b0, 8'h00, 8'h00);
      cyc(1'b0, 8'h00, 8'h00);
      @(posedge Clk);
      #2;
      mon_en = 1'b0;
      Rst    = 1'b1;
      #1;
      check("abort_busy", {31'b0, Busy}, 32'd0);
      check("abort_done", {31'b0, Done}, 32'd0);
      check("abort_sum", {24'b0, Sum}, 32'd0);
      check("abort_carry", {31'b0, Carry}, 32'd0);
      q.delete();
      last_sum   = '0;
      last_carry = 1'b0;
      release_reset();
      idle(3);
      cyc(1'b1, 8'hC3, 8'h7E); idle(10);

      // Randomized traffic, including Start pulses that land mid-run.
      for (int i = 0; i < 60; i++)
         cyc(($urandom_range(0, 2) == 0), $urandom, $urandom);
      Start = 1'b0;

      // Drain outstanding results with a bounded wait.
      for (int i = 0; i < 40; i++) begin
         if (q.size() == 0) break;
         @(negedge Clk);
      end
      check("drain", q.size(), 32'd0);
      @(negedge Clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
